// File: rtl/feed_pkg.sv
// Shared types and constants for the feed progress overlay.
// Holds the FSM encoding, the screen size and the default bar geometry.
package feed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feed_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_TICKS_PER_SEC = 50000000;
  localparam int DEF_NUM_SEGS      = 10;
  localparam int DEF_SEG_W         = 50;
  localparam int DEF_SEG_H         = 80;
  localparam int DEF_SEG_PITCH     = 64;
  localparam int DEF_BAR_X0        = 14;
  localparam int DEF_BAR_Y0        = 10;
  localparam int DEF_DUR_W         = 16;
  localparam int DEF_ADDR_W        = 13;

  // Bit width for a value range 0..v-1; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/feed_seg_locator.sv
// Combinational x/y to segment hit, index and segment-relative coordinates.
// Latency: 0 cycles; no backpressure.
module feed_seg_locator
  import feed_pkg::*;
#(
  parameter int NUM_SEGS  = DEF_NUM_SEGS,
  parameter int SEG_W     = DEF_SEG_W,
  parameter int SEG_H     = DEF_SEG_H,
  parameter int SEG_PITCH = DEF_SEG_PITCH,
  parameter int BAR_X0    = DEF_BAR_X0,
  parameter int BAR_Y0    = DEF_BAR_Y0
) (
  input  logic [9:0]                         i_x,
  input  logic [8:0]                         i_y,
  output logic                               o_hit,
  output logic [clog2_min1(NUM_SEGS)-1:0]    o_seg_idx,
  output logic [clog2_min1(SEG_W)-1:0]       o_x_rel,
  output logic [clog2_min1(SEG_H)-1:0]       o_y_rel
);

  localparam int IDX_W = clog2_min1(NUM_SEGS);
  localparam int XR_W  = clog2_min1(SEG_W);
  localparam int YR_W  = clog2_min1(SEG_H);

  logic                w_y_in;
  logic [NUM_SEGS-1:0] w_hit_vec;

  assign w_y_in = (int'(i_y) >= BAR_Y0) && (int'(i_y) < BAR_Y0 + SEG_H);

  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
    localparam int LEFT = BAR_X0 + g * SEG_PITCH;
    assign w_hit_vec[g] = w_y_in && (int'(i_x) >= LEFT) && (int'(i_x) < LEFT + SEG_W);
  end

  // Segments never overlap (pitch >= width), so at most one bit is set.
  always_comb begin
    o_hit     = 1'b0;
    o_seg_idx = '0;
    o_x_rel   = '0;
    o_y_rel   = '0;
    for (int i = 0; i < NUM_SEGS; i++) begin
      if (w_hit_vec[i]) begin
        o_hit     = 1'b1;
        o_seg_idx = IDX_W'(i);
        o_x_rel   = XR_W'(int'(i_x) - (BAR_X0 + i * SEG_PITCH));
        o_y_rel   = YR_W'(int'(i_y) - BAR_Y0);
      end
    end
  end

endmodule

// File: rtl/feed_progress_overlay.sv
// Feed timer with proportional bar fill (remainder accumulation) and VGA bar overlay.
// Pixel outputs registered, 1-cycle latency from x/y; no backpressure.
module feed_progress_overlay
  import feed_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int NUM_SEGS      = DEF_NUM_SEGS,
  parameter int SEG_W         = DEF_SEG_W,
  parameter int SEG_H         = DEF_SEG_H,
  parameter int SEG_PITCH     = DEF_SEG_PITCH,
  parameter int BAR_X0        = DEF_BAR_X0,
  parameter int BAR_Y0        = DEF_BAR_Y0,
  parameter int DUR_W         = DEF_DUR_W,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_feed,
  input  logic [DUR_W-1:0]                 i_duration,
  input  logic [9:0]                       i_x,
  input  logic [8:0]                       i_y,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [$clog2(NUM_SEGS+1)-1:0]    o_filled,
  output logic                             o_bar_px,
  output logic                             o_fill_px,
  output logic [ADDR_W-1:0]                o_sprite_addr
);

  localparam int FILL_W = $clog2(NUM_SEGS + 1);
  localparam int TICK_W = clog2_min1(TICKS_PER_SEC);
  localparam int ACC_W  = DUR_W + FILL_W + 1;
  localparam int IDX_W  = clog2_min1(NUM_SEGS);
  localparam int XR_W   = clog2_min1(SEG_W);
  localparam int YR_W   = clog2_min1(SEG_H);

  feed_state_t        r_state, w_state_nxt;
  logic [TICK_W-1:0]  r_tick, w_tick_nxt;
  logic [DUR_W-1:0]   r_sec, w_sec_nxt;
  logic [DUR_W-1:0]   r_dur, w_dur_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [FILL_W-1:0]  r_filled, w_filled_nxt;
  logic               r_done, w_done_nxt;
  logic               r_bar_px, r_fill_px;
  logic [ADDR_W-1:0]  r_sprite_addr;

  logic               w_wrap, w_sub;
  logic               w_hit;
  logic [IDX_W-1:0]   w_seg_idx;
  logic [XR_W-1:0]    w_x_rel;
  logic [YR_W-1:0]    w_y_rel;
  logic [ADDR_W-1:0]  w_addr;

  assign w_wrap = (r_tick == TICK_W'(TICKS_PER_SEC - 1));
  // acc holds seconds*NUM_SEGS - filled*dur, so acc >= dur means the bar is behind.
  assign w_sub  = (r_acc >= ACC_W'(r_dur)) && (r_filled < FILL_W'(NUM_SEGS));

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_sec_nxt    = r_sec;
    w_dur_nxt    = r_dur;
    w_acc_nxt    = r_acc;
    w_filled_nxt = r_filled;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_feed) begin
          w_dur_nxt    = i_duration;
          w_tick_nxt   = '0;
          w_sec_nxt    = '0;
          w_acc_nxt    = '0;
          w_filled_nxt = '0;
          if (i_duration == '0) begin
            w_state_nxt  = DONE;
            w_filled_nxt = FILL_W'(NUM_SEGS);
            w_done_nxt   = 1'b1;
          end else begin
            w_state_nxt  = RUN;
          end
        end
      end
      RUN: begin
        if (!i_feed) begin
          w_state_nxt  = IDLE;
          w_filled_nxt = '0;
        end else if (r_sec == r_dur) begin
          w_state_nxt  = DONE;
          w_filled_nxt = FILL_W'(NUM_SEGS);
          w_done_nxt   = 1'b1;
        end else begin
          w_tick_nxt   = w_wrap ? '0 : r_tick + TICK_W'(1);
          w_sec_nxt    = r_sec + DUR_W'(w_wrap);
          w_acc_nxt    = r_acc + (w_wrap ? ACC_W'(NUM_SEGS) : '0)
                               - (w_sub ? ACC_W'(r_dur) : '0);
          w_filled_nxt = r_filled + FILL_W'(w_sub);
        end
      end
      DONE: begin
        w_filled_nxt = FILL_W'(NUM_SEGS);
        if (!i_feed) begin
          w_state_nxt  = IDLE;
          w_filled_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_filled_nxt = '0;
      end
    endcase
  end

  feed_seg_locator #(
    .NUM_SEGS  (NUM_SEGS),
    .SEG_W     (SEG_W),
    .SEG_H     (SEG_H),
    .SEG_PITCH (SEG_PITCH),
    .BAR_X0    (BAR_X0),
    .BAR_Y0    (BAR_Y0)
  ) u_locator (
    .i_x       (i_x),
    .i_y       (i_y),
    .o_hit     (w_hit),
    .o_seg_idx (w_seg_idx),
    .o_x_rel   (w_x_rel),
    .o_y_rel   (w_y_rel)
  );

  assign w_addr = w_hit ? (ADDR_W'(w_x_rel) + ADDR_W'(w_y_rel) * ADDR_W'(SEG_W)) : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_sec         <= '0;
      r_dur         <= '0;
      r_acc         <= '0;
      r_filled      <= '0;
      r_done        <= 1'b0;
      r_bar_px      <= 1'b0;
      r_fill_px     <= 1'b0;
      r_sprite_addr <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tick        <= w_tick_nxt;
      r_sec         <= w_sec_nxt;
      r_dur         <= w_dur_nxt;
      r_acc         <= w_acc_nxt;
      r_filled      <= w_filled_nxt;
      r_done        <= w_done_nxt;
      r_bar_px      <= w_hit;
      r_fill_px     <= w_hit && (int'(w_seg_idx) < int'(r_filled));
      r_sprite_addr <= w_addr;
    end
  end

  assign o_busy        = (r_state == RUN);
  assign o_done        = r_done;
  assign o_filled      = r_filled;
  assign o_bar_px      = r_bar_px;
  assign o_fill_px     = r_fill_px;
  assign o_sprite_addr = r_sprite_addr;

endmodule

// File: tb/tb_feed_progress_overlay.sv
// Randomised and directed bench for feed_progress_overlay against a seconds-based model.
module tb_feed_progress_overlay;
  import feed_pkg::*;

  localparam int TPS    = 10;
  localparam int NSEG   = 10;
  localparam int SW     = 50;
  localparam int SH     = 80;
  localparam int PITCH  = 64;
  localparam int X0     = 14;
  localparam int Y0     = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        feed = 1'b0;
  logic [15:0] duration = '0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        o_busy, o_done, o_bar_px, o_fill_px;
  logic [3:0]  o_filled;
  logic [12:0] o_sprite_addr;

  int checks = 0;
  int errors = 0;

  feed_progress_overlay #(
    .TICKS_PER_SEC (TPS),
    .NUM_SEGS      (NSEG)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_feed        (feed),
    .i_duration    (duration),
    .i_x           (x),
    .i_y           (y),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_filled      (o_filled),
    .o_bar_px      (o_bar_px),
    .o_fill_px     (o_fill_px),
    .o_sprite_addr (o_sprite_addr)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 run, 2 done; m_k counts timer cycles, seconds = m_k / TPS.
  int m_phase = 0, m_k = 0, m_dur = 0, m_filled = 0, m_done = 0;
  int e_bar = 0, e_fill = 0, e_addr = 0;

  task automatic pix_model(input int px, input int py, input int filled,
                           output int bar, output int fill, output int addr);
    bar = 0; fill = 0; addr = 0;
    for (int i = 0; i < NSEG; i++) begin
      int left;
      left = X0 + i * PITCH;
      if (px >= left && px < left + SW && py >= Y0 && py < Y0 + SH) begin
        bar  = 1;
        fill = (i < filled) ? 1 : 0;
        addr = (px - left) + (py - Y0) * SW;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_dur = 0; m_filled = 0; m_done = 0;
      e_bar = 0; e_fill = 0; e_addr = 0;
    end else begin
      int sec, tgt;
      pix_model(int'(x), int'(y), m_filled, e_bar, e_fill, e_addr);
      m_done = 0;
      case (m_phase)
        0: if (feed) begin
          m_dur = int'(duration);
          m_k   = 0;
          if (m_dur == 0) begin
            m_phase = 2; m_filled = NSEG; m_done = 1;
          end else begin
            m_phase = 1; m_filled = 0;
          end
        end
        1: begin
          sec = m_k / TPS;
          if (!feed) begin
            m_phase = 0; m_filled = 0;
          end else if (sec == m_dur) begin
            m_phase = 2; m_filled = NSEG; m_done = 1;
          end else begin
            tgt = (sec * NSEG) / m_dur;
            if (tgt > NSEG) tgt = NSEG;
            if (m_filled < tgt) m_filled++;
            m_k++;
          end
        end
        default: if (!feed) begin
          m_phase = 0; m_filled = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (o_busy !== (m_phase == 1) || o_done !== 1'(m_done) || o_filled !== 4'(m_filled) ||
        o_bar_px !== 1'(e_bar) || o_fill_px !== 1'(e_fill) || o_sprite_addr !== 13'(e_addr)) begin
      errors++;
      $display("FAIL cycle t=%0t busy/done/filled/bar/fill/addr got %0b %0b %0d %0b %0b %0d want %0b %0b %0d %0b %0b %0d",
               $time, o_busy, o_done, o_filled, o_bar_px, o_fill_px, o_sprite_addr,
               (m_phase == 1), m_done, m_filled, e_bar, e_fill, e_addr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(posedge clk);
    #4;
  endtask

  initial begin
    #1;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_filled", int'(o_filled), 0);
    chk("reset_addr", int'(o_sprite_addr), 0);
    steps(2);
    rst_n = 1'b1;
    steps(2);

    // duration 5: two segments per second
    duration = 16'd5; feed = 1'b1;
    steps(20); chk("d5_filled_s1", int'(o_filled), 2); chk("d5_busy", int'(o_busy), 1);
    duration = 16'd1;
    steps(10); chk("d5_filled_s2", int'(o_filled), 4);
    steps(10); chk("d5_filled_s3", int'(o_filled), 6);
    steps(10); chk("d5_filled_s4", int'(o_filled), 8); chk("d5_no_done", int'(o_done), 0);
    steps(2);  chk("d5_done", int'(o_done), 1); chk("d5_full", int'(o_filled), 10);
    chk("d5_busy_drop", int'(o_busy), 0);
    steps(1);  chk("d5_done_1cyc", int'(o_done), 0); chk("d5_hold", int'(o_filled), 10);
    feed = 1'b0;
    steps(1);  chk("d5_idle_clear", int'(o_filled), 0);
    steps(1);

    // duration 3: remainder carried between seconds
    duration = 16'd3; feed = 1'b1;
    steps(20); chk("d3_filled_s1", int'(o_filled), 3);
    steps(10); chk("d3_filled_s2", int'(o_filled), 6);
    steps(2);  chk("d3_done", int'(o_done), 1); chk("d3_full", int'(o_filled), 10);
    feed = 1'b0;
    steps(2);

    // duration 0: straight to done
    duration = 16'd0; feed = 1'b1;
    steps(1); chk("d0_done", int'(o_done), 1); chk("d0_full", int'(o_filled), 10);
    chk("d0_busy", int'(o_busy), 0);
    steps(1); chk("d0_done_1cyc", int'(o_done), 0); chk("d0_busy2", int'(o_busy), 0);
    feed = 1'b0;
    steps(2);

    // abort at second 2 of an 8 second run
    duration = 16'd8; feed = 1'b1;
    steps(25); chk("abort_pre", int'(o_filled), 2);
    feed = 1'b0;
    steps(1); chk("abort_busy", int'(o_busy), 0); chk("abort_filled", int'(o_filled), 0);
    chk("abort_done", int'(o_done), 0);
    feed = 1'b1;
    steps(5); chk("restart_busy", int'(o_busy), 1); chk("restart_filled", int'(o_filled), 0);
    feed = 1'b0;
    steps(2);

    // pixel sweep with three segments lit
    duration = 16'd10; feed = 1'b1;
    steps(33);
    x = 10'd14; y = 9'd10;
    steps(1); chk("px0_bar", int'(o_bar_px), 1); chk("px0_fill", int'(o_fill_px), 1);
    chk("px0_addr", int'(o_sprite_addr), 0); chk("px_filled3", int'(o_filled), 3);
    x = 10'd64;
    steps(1); chk("gap_bar", int'(o_bar_px), 0); chk("gap_addr", int'(o_sprite_addr), 0);
    x = 10'd270; y = 9'd11;
    steps(1); chk("seg4_bar", int'(o_bar_px), 1); chk("seg4_fill", int'(o_fill_px), 0);
    chk("seg4_addr", int'(o_sprite_addr), 50);
    x = 10'd14; y = 9'd90;
    steps(1); chk("bottom_bar", int'(o_bar_px), 0);
    feed = 1'b0;
    steps(2);

    // asynchronous reset mid-run, then re-latch a new duration
    duration = 16'd6; feed = 1'b1; x = 10'd20; y = 9'd20;
    steps(35);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(o_busy), 0); chk("arst_filled", int'(o_filled), 0);
    chk("arst_bar", int'(o_bar_px), 0); chk("arst_addr", int'(o_sprite_addr), 0);
    duration = 16'd2;
    steps(2);
    rst_n = 1'b1;
    steps(20); chk("rerun_filled", int'(o_filled), 5);
    steps(2);  chk("rerun_done", int'(o_done), 1);
    feed = 1'b0;
    steps(2);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) feed = ~feed;
      duration = 16'($urandom_range(0, 3));
      x = 10'($urandom_range(0, H_ACTIVE - 1));
      y = 9'($urandom_range(0, 127));
      steps(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feed_progress_overlay.md
Name: feed_progress_overlay

Overview:
Parametrised successor to the fixed 10-cell feed progress display. It runs a feed timer for any run-time duration and fills NUM_SEGS bar segments in proportion to elapsed seconds, using remainder accumulation with no divider. It overlays the bar onto the VGA pixel stream with a registered sprite address. It sits between the feed controller (feed, duration) and the VGA pixel mux.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; must be >= 4*NUM_SEGS
NUM_SEGS, 10, number of bar segments (1..32)
SEG_W, 50, segment width in pixels
SEG_H, 80, segment height in pixels
SEG_PITCH, 64, x distance between segment left edges; must be >= SEG_W
BAR_X0, 14, x of segment 0 left edge
BAR_Y0, 10, y of segment top edge
DUR_W, 16, width of duration/seconds counters
ADDR_W, 13, sprite address width; 2^ADDR_W >= SEG_W*SEG_H

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
feed  in  1  level; high = feeding requested
duration  in  DUR_W  feed length in seconds; sampled only on IDLE->RUN
x  in  10  current pixel column
y  in  9  current pixel row
busy  out  1  high in RUN
done  out  1  one-cycle pulse on RUN->DONE
filled  out  $clog2(NUM_SEGS+1)  segments currently lit
bar_px  out  1  pixel lies inside any segment rectangle
fill_px  out  1  pixel lies inside a segment with index < filled
sprite_addr  out  ADDR_W  (x - seg_left) + (y - BAR_Y0)*SEG_W; 0 when bar_px low

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; tick counter, seconds, accumulator, filled, busy, done, bar_px, fill_px and sprite_addr all 0.
- FSM IDLE: when feed=1, latch dur_q=duration, clear tick/seconds/acc/filled, go RUN. If duration=0, go directly to DONE with filled=NUM_SEGS and pulse done on the next cycle.
- FSM RUN: tick counter counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap (second tick): seconds+1 and acc+=NUM_SEGS.
  - Every cycle with acc>=dur_q and filled<NUM_SEGS: acc-=dur_q and filled+1. This is one subtraction per cycle, so it settles well before the next tick.
  - When seconds==dur_q: force filled=NUM_SEGS, go DONE, and assert done for exactly 1 cycle.
- FSM DONE: hold filled=NUM_SEGS. When feed=0, go IDLE and clear filled.
- feed=0 in RUN aborts: go IDLE next cycle, filled=0, no done pulse.
- Changes on the duration input while in RUN or DONE are ignored.
- The acc width must hold dur_q+NUM_SEGS without overflow.
- Pixel path, 1-cycle latency: x and y are compared combinationally and all outputs are registered.
  - Segment i spans x in [BAR_X0+i*SEG_PITCH, BAR_X0+i*SEG_PITCH+SEG_W) and y in [BAR_Y0, BAR_Y0+SEG_H), with the right and bottom edges exclusive.
  - Gaps between segments give bar_px=0.
  - fill_px uses the filled value of the same cycle the x/y are sampled.
  - Segments extending past x=639 are clipped naturally; no wrap.
- A second feed request after DONE needs feed to go low (back to IDLE) and then high again.

Decomposition:
- Shared package feed_pkg holds:
  - FSM state enum (IDLE, RUN, DONE);
  - screen constants H_ACTIVE=640, V_ACTIVE=480;
  - the default geometry constants.
- One sub-module, feed_seg_locator, is natural: combinational x/y to {hit, seg_idx, x_rel, y_rel}, generated over NUM_SEGS. The top module registers its outputs and owns the FSM and timer.

Test Plan:
1. TICKS_PER_SEC=10, NUM_SEGS=10, duration=5, feed high. Required: filled=2,4,6,8 within 12 cycles of each tick; at tick 5 filled=10, done pulses 1 cycle, busy drops.
2. duration=3, NUM_SEGS=10. Required: filled=3 after sec1, 6 after sec2 (acc remainder 2), 10 plus done at sec3.
3. duration=0, feed rises. Required: filled=10 and one done pulse with no ticks elapsed; busy never asserts.
4. feed dropped at second 2 of a duration=8 run. Required: next cycle state IDLE, filled=0, no done pulse; a new feed pulse restarts from filled=0.
5. Pixel sweep, default geometry, filled=3. Required:
   - x=14,y=10 -> bar_px=1, fill_px=1, sprite_addr=0 one cycle later;
   - x=64 (gap) -> bar_px=0;
   - x=270,y=11 -> bar_px=1, fill_px=0, sprite_addr=50;
   - y=90 -> bar_px=0.
6. reset asserted mid-run at second 3, deasserted while feed stays high. Required: all outputs 0 immediately and asynchronously; after release a fresh run starts with duration re-latched.
